// File: rtl/scratchmem_pipe_fta.sv
// Pipelined scratchpad RAM for the FTA bus: credit-stalled requests,
// in-order responses through a registered-head response FIFO.
module scratchmem_pipe_fta #(
    parameter int DATA_WID = 256,
    parameter int DEPTH    = 16384,
    parameter int ADR_WID  = 32,
    parameter int RD_LAT   = 2,
    parameter int RSP_DEP  = 8,
    parameter int TID_WID  = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cs_i,
    input  logic                  req_cyc,
    input  logic                  req_stb,
    input  logic                  req_we,
    input  logic                  req_erc,
    input  logic [DATA_WID/8-1:0] req_sel,
    input  logic [ADR_WID-1:0]    req_adr,
    input  logic [DATA_WID-1:0]   req_dat,
    input  logic [TID_WID-1:0]    req_tid,
    output logic                  req_stall,
    output logic                  resp_vld,
    input  logic                  resp_rdy,
    output logic                  resp_ack,
    output logic                  resp_err,
    output logic [TID_WID-1:0]    resp_tid,
    output logic [ADR_WID-1:0]    resp_adr,
    output logic [DATA_WID-1:0]   resp_dat
);

    localparam int NB = DATA_WID / 8;
    localparam int LB = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(RSP_DEP);
    localparam int CW = $clog2(RSP_DEP + 1);

    typedef struct packed {
        logic               vld;
        logic               rd;
        logic               err;
        logic [TID_WID-1:0] tid;
        logic [ADR_WID-1:0] adr;
    } pipe_t;

    typedef struct packed {
        logic                ack;
        logic                err;
        logic [TID_WID-1:0]  tid;
        logic [ADR_WID-1:0]  adr;
        logic [DATA_WID-1:0] dat;
    } ent_t;

    logic [IW-1:0]       idx;
    logic                oor;
    logic                accept;
    logic                rsp_req;
    logic                pop;
    logic                push;
    logic [CW-1:0]       outst;
    logic [DATA_WID-1:0] ram [DEPTH];
    logic [DATA_WID-1:0] rd_q [RD_LAT];
    pipe_t               pipe [RD_LAT];
    ent_t                push_ent;
    ent_t                fifo [RSP_DEP];
    ent_t                head;
    ent_t                head_n;
    logic [PW-1:0]       wptr;
    logic [PW-1:0]       rptr;
    logic [PW-1:0]       rptr_n;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       cnt_left;
    logic [CW-1:0]       cnt_n;

    assign idx       = req_adr[LB +: IW];
    assign oor       = |(req_adr >> (LB + IW));
    assign req_stall = (outst == CW'(RSP_DEP));
    assign accept    = cs_i & req_cyc & req_stb & ~req_stall;
    assign rsp_req   = ~req_we | req_erc | oor;
    assign pop       = resp_vld & resp_rdy;

    // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            outst <= '0;
        end else if ((accept & rsp_req) & ~pop) begin
            outst <= outst + 1'b1;
        end else if (~(accept & rsp_req) & pop) begin
            outst <= outst - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept & req_we & ~oor) begin
            for (int i = 0; i < NB; i++) begin
                if (req_sel[i]) ram[idx][i*8 +: 8] <= req_dat[i*8 +: 8];
            end
        end
        rd_q[0] <= ram[idx];
        for (int k = 1; k < RD_LAT; k++) rd_q[k] <= rd_q[k-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < RD_LAT; k++) pipe[k] <= '0;
        end else begin
            pipe[0].vld <= accept & rsp_req;
            pipe[0].rd  <= ~req_we;
            pipe[0].err <= oor;
            pipe[0].tid <= req_tid;
            pipe[0].adr <= req_adr;
            for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
        end
    end

    assign push         = pipe[RD_LAT-1].vld;
    assign push_ent.ack = ~pipe[RD_LAT-1].err;
    assign push_ent.err = pipe[RD_LAT-1].err;
    assign push_ent.tid = pipe[RD_LAT-1].tid;
    assign push_ent.adr = pipe[RD_LAT-1].adr;
    assign push_ent.dat = (pipe[RD_LAT-1].rd & ~pipe[RD_LAT-1].err)
                          ? rd_q[RD_LAT-1] : '0;

    always_ff @(posedge clk_i) begin
        if (push) fifo[wptr] <= push_ent;
    end

    // Next head comes from storage, or straight from the push when
    // the FIFO is otherwise empty after this cycle's pop.
    always_comb begin
        rptr_n   = pop ? rptr + 1'b1 : rptr;
        cnt_left = cnt - CW'(pop);
        cnt_n    = cnt_left + CW'(push);
        head_n   = '0;
        if (cnt_n != '0) begin
            head_n = (cnt_left == '0) ? push_ent : fifo[rptr_n];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            head <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            rptr <= rptr_n;
            cnt  <= cnt_n;
            head <= head_n;
        end
    end

    assign resp_vld = (cnt != '0);
    assign resp_ack = head.ack;
    assign resp_err = head.err;
    assign resp_tid = head.tid;
    assign resp_adr = head.adr;
    assign resp_dat = head.dat;

endmodule

// File: tb/tb_scratchmem_pipe_fta.sv
// Scoreboard bench for scratchmem_pipe_fta: directed requests push expected
// responses, a negedge monitor pops and compares them in order.
module tb_scratchmem_pipe_fta;

    localparam int DW = 64;
    localparam int AW = 32;
    localparam int TW = 13;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cs_i, req_cyc, req_stb, req_we, req_erc;
    logic [DW/8-1:0] req_sel;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat;
    logic [TW-1:0] req_tid;
    logic          req_stall, resp_vld, resp_rdy, resp_ack, resp_err;
    logic [TW-1:0] resp_tid;
    logic [AW-1:0] resp_adr;
    logic [DW-1:0] resp_dat;

    typedef struct {
        logic          ack;
        logic          err;
        logic [TW-1:0] tid;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   stall_cnt = 0;
    int   acc;
    int   nv;
    int   t0;

    localparam logic [DW-1:0] PAT  = 64'h1111_1111_1111_1111;
    localparam logic [DW-1:0] PATA = 64'h1111_1111_1111_11AA;
    localparam logic [DW-1:0] PATB = 64'hBB11_1111_1111_11AA;
    localparam logic [DW-1:0] P0   = 64'h0123_4567_89AB_CDEF;

    scratchmem_pipe_fta #(
        .DATA_WID(DW), .DEPTH(1024), .ADR_WID(AW),
        .RD_LAT(2), .RSP_DEP(8), .TID_WID(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cs_i(cs_i),
        .req_cyc(req_cyc), .req_stb(req_stb), .req_we(req_we),
        .req_erc(req_erc), .req_sel(req_sel), .req_adr(req_adr),
        .req_dat(req_dat), .req_tid(req_tid), .req_stall(req_stall),
        .resp_vld(resp_vld), .resp_rdy(resp_rdy), .resp_ack(resp_ack),
        .resp_err(resp_err), .resp_tid(resp_tid), .resp_adr(resp_adr),
        .resp_dat(resp_dat)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    always @(negedge clk_i) begin
        if (!rst_i && resp_vld && resp_rdy) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp got tid=%0h adr=%0h", resp_tid, resp_adr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (resp_ack !== e.ack || resp_err !== e.err || resp_tid !== e.tid ||
                    resp_adr !== e.adr || resp_dat !== e.dat) begin
                    failures++;
                    $display("FAIL resp got ack=%b err=%b tid=%0h adr=%0h dat=%h want ack=%b err=%b tid=%0h adr=%0h dat=%h",
                             resp_ack, resp_err, resp_tid, resp_adr, resp_dat,
                             e.ack, e.err, e.tid, e.adr, e.dat);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic ack, input logic err, input logic [TW-1:0] tid,
                            input logic [AW-1:0] adr, input logic [DW-1:0] dat);
        exp_t e;
        e.ack = ack; e.err = err; e.tid = tid; e.adr = adr; e.dat = dat;
        sb.push_back(e);
    endtask

    task automatic req(input logic we, input logic erc, input logic [7:0] sel,
                       input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       input logic [TW-1:0] tid, input logic rsp, input logic err,
                       input logic [DW-1:0] edat);
        bit ok;
        ok = 0;
        cs_i = 1; req_cyc = 1; req_stb = 1;
        req_we = we; req_erc = erc; req_sel = sel;
        req_adr = adr; req_dat = dat; req_tid = tid;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (!req_stall) begin
                ok = 1;
                break;
            end
            stall_cnt++;
            @(posedge clk_i);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout tid=%0h", tid);
        end else if (rsp) begin
            push_exp(~err, err, tid, adr, edat);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle;
        cs_i = 0; req_cyc = 0; req_stb = 0; req_we = 0; req_erc = 0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((sb.size() != 0 || resp_vld) && n < 200) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        check("drain_left", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst_i = 1; resp_rdy = 1;
        cs_i = 0; req_cyc = 0; req_stb = 0; req_we = 0; req_erc = 0;
        req_sel = '0; req_adr = '0; req_dat = '0; req_tid = '0;
        #2;
        check("reset_vld", 64'(resp_vld), 64'd0);
        check("reset_outs", {resp_ack, resp_err, resp_tid, resp_adr}, 64'd0);
        check("reset_stall", 64'(req_stall), 64'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_i = 0;
        @(posedge clk_i);
        #1;

        // full write with ack, then readback in order
        req(1, 1, 8'hFF, 32'h40, PAT, 13'd1, 1, 0, '0);
        req(0, 0, 8'h00, 32'h40, '0, 13'd2, 1, 0, PAT);
        idle();
        drain();

        // byte lane writes, erc=0 write produces nothing
        req(1, 1, 8'h01, 32'h40, 64'hAA, 13'd3, 1, 0, '0);
        req(0, 0, 8'h00, 32'h40, '0, 13'd4, 1, 0, PATA);
        idle();
        drain();
        req(1, 0, 8'h80, 32'h40, 64'hBB00_0000_0000_0000, 13'd5, 0, 0, '0);
        idle();
        nv = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (resp_vld) nv++;
        end
        check("erc0_no_resp", 64'(nv), 64'd0);
        @(posedge clk_i);
        #1;
        req(0, 0, 8'h00, 32'h40, '0, 13'd6, 1, 0, PATB);
        req(1, 1, 8'hFF, 32'h0, P0, 13'd7, 1, 0, '0);
        idle();
        drain();

        // out of range: error responses, no aliasing onto index 0
        req(0, 0, 8'h00, 32'h2000, '0, 13'd8, 1, 1, '0);
        req(1, 0, 8'hFF, 32'h2000, '1, 13'd9, 1, 1, '0);
        req(0, 0, 8'h00, 32'h0, '0, 13'd10, 1, 0, P0);
        req(0, 0, 8'h00, 32'h8000_0000, '0, 13'd11, 1, 1, '0);
        idle();
        drain();

        // backpressure: 8 credits, then one more per pop
        resp_rdy = 0;
        acc = 0;
        cs_i = 1; req_cyc = 1; req_stb = 1; req_we = 0; req_erc = 0;
        req_adr = 32'h40; req_tid = 13'h100;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            if (!req_stall) begin
                push_exp(1, 0, req_tid, 32'h40, PATB);
                acc++;
            end
            @(posedge clk_i);
            #1;
            req_tid = 13'(13'h100 + acc);
        end
        check("bp_accepted", 64'(acc), 64'd8);
        check("bp_stall", 64'(req_stall), 64'd1);
        resp_rdy = 1;
        @(posedge clk_i);
        #1 resp_rdy = 0;
        @(negedge clk_i);
        check("bp_credit_back", 64'(req_stall), 64'd0);
        if (!req_stall) begin
            push_exp(1, 0, req_tid, 32'h40, PATB);
            acc++;
        end
        @(posedge clk_i);
        #1 idle();
        @(negedge clk_i);
        check("bp_restall", 64'(req_stall), 64'd1);
        check("bp_total", 64'(acc), 64'd9);
        @(posedge clk_i);
        #1 resp_rdy = 1;
        drain();

        // sustained throughput with push and pop together
        stall_cnt = 0;
        t0 = $time;
        for (int i = 0; i < 12; i++)
            req(0, 0, 8'h00, 32'h40, '0, 13'(13'h200 + i), 1, 0, PATB);
        idle();
        drain();
        check("tp_no_stall", 64'(stall_cnt), 64'd0);
        checks++;
        if (($time - t0) / 10 > 18) begin
            failures++;
            $display("FAIL tp_cycles got=%0d want<=18", ($time - t0) / 10);
        end

        // reset mid-burst with 5 outstanding
        resp_rdy = 0;
        for (int i = 0; i < 5; i++)
            req(0, 0, 8'h00, 32'h40, '0, 13'(13'h300 + i), 1, 0, PATB);
        idle();
        #2 rst_i = 1;
        #1;
        check("rst_vld", 64'(resp_vld), 64'd0);
        check("rst_outs", {resp_ack, resp_err, resp_tid, resp_adr}, 64'd0);
        check("rst_dat", resp_dat, 64'd0);
        check("rst_stall", 64'(req_stall), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        resp_rdy = 1;
        nv = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (resp_vld) nv++;
        end
        check("rst_no_vld_after", 64'(nv), 64'd0);
        @(posedge clk_i);
        #1;
        req(0, 0, 8'h00, 32'h40, '0, 13'h3F0, 1, 0, PATB);
        req(0, 0, 8'h00, 32'h0, '0, 13'h3F1, 1, 0, P0);
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
